// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: default width, maximal-length tap masks and parity.
// Tap masks use bit i = state[i] for a left-shifting Fibonacci register.
package lfsr_pkg;

  localparam int DEFAULT_WIDTH = 8;

  function automatic logic parity(input logic [31:0] v);
    return ^v;
  endfunction

  // Maximal-length feedback masks for widths 2..32; unsupported widths give 0.
  function automatic logic [31:0] max_taps(input int w);
    logic [31:0] t;
    case (w)
      2:       t = 32'h0000_0003;
      3:       t = 32'h0000_0006;
      4:       t = 32'h0000_000C;
      5:       t = 32'h0000_0014;
      6:       t = 32'h0000_0030;
      7:       t = 32'h0000_0060;
      8:       t = 32'h0000_00B8;
      9:       t = 32'h0000_0110;
      10:      t = 32'h0000_0240;
      11:      t = 32'h0000_0500;
      12:      t = 32'h0000_0829;
      13:      t = 32'h0000_100D;
      14:      t = 32'h0000_2015;
      15:      t = 32'h0000_6000;
      16:      t = 32'h0000_D008;
      17:      t = 32'h0001_2000;
      18:      t = 32'h0002_0400;
      19:      t = 32'h0004_0023;
      20:      t = 32'h0009_0000;
      21:      t = 32'h0014_0000;
      22:      t = 32'h0030_0000;
      23:      t = 32'h0042_0000;
      24:      t = 32'h00E1_0000;
      25:      t = 32'h0120_0000;
      26:      t = 32'h0200_0023;
      27:      t = 32'h0400_0013;
      28:      t = 32'h0900_0000;
      29:      t = 32'h1400_0000;
      30:      t = 32'h2000_0029;
      31:      t = 32'h4800_0000;
      32:      t = 32'h8020_0003;
      default: t = 32'h0000_0000;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Combinational Fibonacci LFSR step: shifts left and inserts the tap parity at bit 0.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int                WIDTH = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(max_taps(WIDTH))
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next_state
);

  logic fb;

  assign fb         = parity(32'(state & TAPS));
  assign next_state = {state[WIDTH-2:0], fb};

endmodule

// File: rtl/lfsr_period_gen.sv
// LFSR PRBS source with seed-return period measurement, lock-up and no-return flags.
module lfsr_period_gen
  import lfsr_pkg::*;
#(
  parameter int                WIDTH = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(max_taps(WIDTH))
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             en,
  output logic [WIDTH-1:0] data,
  output logic             out,
  output logic [WIDTH-1:0] period,
  output logic             period_done,
  output logic             period_valid,
  output logic             lockup,
  output logic             no_return
);

  localparam logic [WIDTH-1:0] CNT_LIMIT = '1;

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] start;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] nxt_state;
  logic [WIDTH-1:0] cnt_inc;
  logic             returned;
  logic             expired;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_core (
    .state      (state),
    .next_state (nxt_state)
  );

  assign cnt_inc  = cnt + WIDTH'(1);
  assign returned = (nxt_state == start);
  // A state that has not come back within 2^WIDTH-1 steps never will.
  assign expired  = (cnt_inc == CNT_LIMIT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= '0;
      start        <= '0;
      cnt          <= '0;
      period       <= '0;
      period_done  <= 1'b0;
      period_valid <= 1'b0;
      no_return    <= 1'b0;
    end else begin
      period_done <= 1'b0;
      if (load) begin
        state        <= seed;
        start        <= seed;
        cnt          <= '0;
        period_valid <= 1'b0;
        no_return    <= 1'b0;
      end else if (en) begin
        state <= nxt_state;
        if (returned) begin
          period       <= cnt_inc;
          period_done  <= 1'b1;
          period_valid <= 1'b1;
          cnt          <= '0;
        end else if (expired) begin
          no_return <= 1'b1;
          cnt       <= '0;
        end else begin
          cnt <= cnt_inc;
        end
      end
    end
  end

  assign data   = state;
  assign out    = state[WIDTH-1];
  assign lockup = (state == '0);

endmodule

// File: tb/tb_lfsr_period_gen.sv
// Four LFSR configurations driven together, checked against an orbit-based model.
module tb_lfsr_period_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, load, en;
  int   sd [4];

  logic [3:0] seed_a, seed_b, seed_c, data_a, data_b, data_c, per_a, per_b, per_c;
  logic [7:0] seed_d, data_d, per_d;
  logic out_a, out_b, out_c, out_d, pd_a, pd_b, pd_c, pd_d;
  logic pv_a, pv_b, pv_c, pv_d, lk_a, lk_b, lk_c, lk_d, nr_a, nr_b, nr_c, nr_d;

  assign seed_a = 4'(sd[0]);
  assign seed_b = 4'(sd[1]);
  assign seed_c = 4'(sd[2]);
  assign seed_d = 8'(sd[3]);

  lfsr_period_gen #(.WIDTH(4), .TAPS(4'hC)) dut_a (
    .clk(clk), .rst(rst), .load(load), .seed(seed_a), .en(en), .data(data_a), .out(out_a),
    .period(per_a), .period_done(pd_a), .period_valid(pv_a), .lockup(lk_a), .no_return(nr_a));
  lfsr_period_gen #(.WIDTH(4), .TAPS(4'hF)) dut_b (
    .clk(clk), .rst(rst), .load(load), .seed(seed_b), .en(en), .data(data_b), .out(out_b),
    .period(per_b), .period_done(pd_b), .period_valid(pv_b), .lockup(lk_b), .no_return(nr_b));
  lfsr_period_gen #(.WIDTH(4), .TAPS(4'h3)) dut_c (
    .clk(clk), .rst(rst), .load(load), .seed(seed_c), .en(en), .data(data_c), .out(out_c),
    .period(per_c), .period_done(pd_c), .period_valid(pv_c), .lockup(lk_c), .no_return(nr_c));
  lfsr_period_gen #(.WIDTH(8), .TAPS(8'hB8)) dut_d (
    .clk(clk), .rst(rst), .load(load), .seed(seed_d), .en(en), .data(data_d), .out(out_d),
    .period(per_d), .period_done(pd_d), .period_valid(pv_d), .lockup(lk_d), .no_return(nr_d));

  int o_data [4], o_per [4];
  bit o_out [4], o_pd [4], o_pv [4], o_lk [4], o_nr [4];
  always_comb begin
    o_data = '{int'(data_a), int'(data_b), int'(data_c), int'(data_d)};
    o_per  = '{int'(per_a), int'(per_b), int'(per_c), int'(per_d)};
    o_out  = '{out_a, out_b, out_c, out_d};
    o_pd   = '{pd_a, pd_b, pd_c, pd_d};
    o_pv   = '{pv_a, pv_b, pv_c, pv_d};
    o_lk   = '{lk_a, lk_b, lk_c, lk_d};
    o_nr   = '{nr_a, nr_b, nr_c, nr_d};
  end

  // Reference model: the seed's orbit length is found once per load, and every
  // event after that follows from the step count since the load.
  int mw [4] = '{4, 4, 4, 8};
  int mt [4] = '{'hC, 'hF, 'h3, 'hB8};
  int m_state [4], m_seed [4], m_k [4], m_p [4], m_period [4];
  bit m_pd [4], m_pv [4], m_nr [4];

  int n_chk  = 0;
  int n_pass = 0;

  function automatic int lfsr_next(int s, int w, int t);
    return ((s << 1) | ($countones(s & t) & 1)) & ((1 << w) - 1);
  endfunction

  function automatic int orbit_len(int s0, int w, int t);
    int s = lfsr_next(s0, w, t);
    for (int i = 1; i < (1 << w); i++) begin
      if (s == s0) return i;
      s = lfsr_next(s, w, t);
    end
    return 0;
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 4; i++) begin
      m_pd[i] = 1'b0;
      if (!rst) begin
        m_state[i] = 0; m_seed[i] = 0; m_k[i] = 0; m_period[i] = 0;
        m_pv[i] = 1'b0; m_nr[i] = 1'b0;
        m_p[i] = orbit_len(0, mw[i], mt[i]);
      end else if (load) begin
        m_state[i] = sd[i] & ((1 << mw[i]) - 1);
        m_seed[i]  = m_state[i];
        m_k[i]     = 0;
        m_pv[i]    = 1'b0;
        m_nr[i]    = 1'b0;
        m_p[i]     = orbit_len(m_seed[i], mw[i], mt[i]);
      end else if (en) begin
        m_state[i] = lfsr_next(m_state[i], mw[i], mt[i]);
        m_k[i]++;
        if (m_p[i] != 0) begin
          if (m_k[i] % m_p[i] == 0) begin
            m_period[i] = m_p[i]; m_pd[i] = 1'b1; m_pv[i] = 1'b1;
          end
        end else if (m_k[i] % ((1 << mw[i]) - 1) == 0) begin
          m_nr[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    else n_pass++;
  endtask

  task automatic check_all();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("d%0d_data", i), o_data[i], m_state[i]);
      chk($sformatf("d%0d_out", i), o_out[i], (m_state[i] >> (mw[i] - 1)) & 1);
      chk($sformatf("d%0d_period", i), o_per[i], m_period[i]);
      chk($sformatf("d%0d_pdone", i), o_pd[i], m_pd[i]);
      chk($sformatf("d%0d_pvalid", i), o_pv[i], m_pv[i]);
      chk($sformatf("d%0d_lockup", i), o_lk[i], m_state[i] == 0);
      chk($sformatf("d%0d_noret", i), o_nr[i], m_nr[i]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  int seq_c [15] = '{'h2, 'h4, 'h9, 'h3, 'h6, 'hD, 'hA, 'h5, 'hB, 'h7, 'hF, 'hE, 'hC, 'h8, 'h1};
  int seq_f [5]  = '{'h3, 'h6, 'hC, 'h8, 'h1};

  initial begin
    rst = 1'b0; load = 1'b0; en = 1'b0; sd = '{0, 0, 0, 0};
    step(); step();
    chk("rst_data", o_data[3], 0);
    chk("rst_period", o_per[3], 0);
    chk("rst_lockup", o_lk[0], 1);

    rst = 1'b1; sd = '{1, 1, 8, 1}; load = 1'b1;
    step();
    load = 1'b0; en = 1'b1;
    for (int j = 0; j < 300; j++) begin
      step();
      if (j < 15) chk("seq_taps_c", o_data[0], seq_c[j]);
      if (j < 5)  chk("seq_taps_f", o_data[1], seq_f[j]);
      if (j == 14 || j == 29) begin
        chk("p15_done", o_pd[0], 1);
        chk("p15_value", o_per[0], 15);
        chk("lock_noret", o_nr[2], 1);
        chk("lock_pvalid", o_pv[2], 0);
      end
      if (j == 4) chk("p5_value", o_per[1], 5);
      if (j == 0) chk("lock_step1", o_lk[2], 1);
      if (j == 254) begin
        chk("p255_done", o_pd[3], 1);
        chk("p255_value", o_per[3], 255);
      end
    end
    chk("p255_noret", o_nr[3], 0);

    sd = '{'h9, 'h2, 'h5, 'h3C}; load = 1'b1;
    step();
    chk("ld_en_data", o_data[0], 'h9);
    chk("ld_en_pkeep", o_per[0], 15);
    chk("ld_en_pvalid", o_pv[0], 0);
    load = 1'b0;
    repeat (7) step();
    rst = 1'b0;
    step();
    chk("mid_rst_data", o_data[3], 0);
    chk("mid_rst_period", o_per[3], 0);
    rst = 1'b1; en = 1'b0;
    step();
    sd = '{1, 1, 1, 'h5A}; load = 1'b1;
    step();
    load = 1'b0; en = 1'b1;
    repeat (256) step();
    chk("relock_period", o_per[3], 255);

    for (int c = 0; c < 4000; c++) begin
      rst  = ($urandom_range(0, 999) != 0);
      load = ($urandom_range(0, 199) == 0);
      en   = ($urandom_range(0, 3) != 0);
      if (load) for (int i = 0; i < 4; i++) sd[i] = int'($urandom) & ((1 << mw[i]) - 1);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
